// File: rtl/key_ingress_fifo_if.sv
// Consumer-side stream of the key ingress FIFO: head key, folded index and valid/ready.
// The FIFO drives the master side and the bloom counter stage sits on the slave side.
interface key_ingress_fifo_if #(
    parameter int KEY_W = 8,
    parameter int IDX_W = 4
);
    logic [KEY_W-1:0] key_o;
    logic [IDX_W-1:0] idx_o;
    logic             key_valid_o;
    logic             key_ready_i;

    modport master (
        output key_o,
        output idx_o,
        output key_valid_o,
        input  key_ready_i
    );

    modport slave (
        input  key_o,
        input  idx_o,
        input  key_valid_o,
        output key_ready_i
    );
endinterface

// File: rtl/key_ingress_fifo.sv
// Synchronises an asynchronous key bus and strobe into user_clock2, pushes one key per strobe
// rising edge into a small first-word-fall-through FIFO and tracks dropped keys.
module key_ingress_fifo #(
    parameter int KEY_W       = 8,
    parameter int IDX_W       = 4,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     user_clock2,
    input  logic                     rst_n,
    input  logic [KEY_W-1:0]         raw_key,
    input  logic                     raw_strobe,
    input  logic                     clear_i,
    key_ingress_fifo_if.master       stream,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     overflow_o,
    output logic [7:0]               drop_cnt_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    function automatic logic [IDX_W-1:0] fold_idx(input logic [KEY_W-1:0] k);
        logic [IDX_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < KEY_W / IDX_W; i++) begin
            acc = acc ^ k[i*IDX_W +: IDX_W];
        end
        return acc;
    endfunction

    logic [KEY_W:0]       sync_r [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] fill_r;
    logic                 strobe_d_r;
    logic                 armed_r;
    logic [AW:0]          wr_ptr_r;
    logic [AW:0]          rd_ptr_r;
    logic [KEY_W-1:0]     mem_r [DEPTH];

    logic                 s_strobe_s;
    logic [KEY_W-1:0]     s_key_s;
    logic                 rise_s;
    logic [AW:0]          level_s;
    logic                 valid_s;
    logic                 full_s;
    logic                 pop_s;
    logic                 push_s;
    logic                 drop_s;

    // Strobe and key travel together as one word so they stay cycle-aligned.
    always_ff @(posedge user_clock2 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_r[i] <= '0;
            end
        end else begin
            sync_r[0] <= {raw_strobe, raw_key};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
        end
    end

    // Edge detector; armed only once a genuine low strobe has been seen after reset,
    // so the zeros flushed through the synchroniser do not fake a rising edge.
    always_ff @(posedge user_clock2 or negedge rst_n) begin
        if (!rst_n) begin
            fill_r     <= '0;
            strobe_d_r <= 1'b0;
            armed_r    <= 1'b0;
        end else begin
            fill_r     <= {fill_r[SYNC_STAGES-2:0], 1'b1};
            strobe_d_r <= s_strobe_s;
            armed_r    <= armed_r | (fill_r[SYNC_STAGES-1] & ~s_strobe_s);
        end
    end

    // Push/pop decode; a full FIFO still accepts a push when the head leaves in the same cycle.
    always_comb begin
        s_strobe_s = sync_r[SYNC_STAGES-1][KEY_W];
        s_key_s    = sync_r[SYNC_STAGES-1][KEY_W-1:0];
        rise_s     = s_strobe_s & ~strobe_d_r & armed_r;
        level_s    = wr_ptr_r - rd_ptr_r;
        valid_s    = (level_s != '0);
        full_s     = (level_s == FULL_LVL);
        pop_s      = valid_s & stream.key_ready_i;
        push_s     = rise_s & (~full_s | pop_s);
        drop_s     = rise_s & full_s & ~pop_s;
    end

    // Wrap-bit pointers
    always_ff @(posedge user_clock2 or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else if (clear_i) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            wr_ptr_r <= wr_ptr_r + (AW+1)'(push_s);
            rd_ptr_r <= rd_ptr_r + (AW+1)'(pop_s);
        end
    end

    // Storage array
    always_ff @(posedge user_clock2) begin
        if (push_s && !clear_i) begin
            mem_r[wr_ptr_r[AW-1:0]] <= s_key_s;
        end
    end

    // Sticky overflow flag and saturating drop counter
    always_ff @(posedge user_clock2 or negedge rst_n) begin
        if (!rst_n) begin
            overflow_o <= 1'b0;
            drop_cnt_o <= 8'd0;
        end else if (clear_i) begin
            overflow_o <= 1'b0;
            drop_cnt_o <= 8'd0;
        end else if (drop_s) begin
            overflow_o <= 1'b1;
            if (drop_cnt_o != 8'hFF) begin
                drop_cnt_o <= drop_cnt_o + 8'd1;
            end else begin
                drop_cnt_o <= drop_cnt_o;
            end
        end else begin
            overflow_o <= overflow_o;
            drop_cnt_o <= drop_cnt_o;
        end
    end

    // Head presentation; an empty FIFO shows zero rather than a stale entry.
    always_comb begin
        stream.key_valid_o = valid_s;
        level_o            = level_s;
        if (valid_s) begin
            stream.key_o = mem_r[rd_ptr_r[AW-1:0]];
        end else begin
            stream.key_o = '0;
        end
        stream.idx_o = fold_idx(stream.key_o);
    end
endmodule

// File: tb/tb_key_ingress_fifo.sv
// Directed bench for key_ingress_fifo: latency, ordering, overflow, saturation, clear and reset.
module tb_key_ingress_fifo;
    logic       user_clock2;
    logic       rst_n;
    logic [7:0] raw_key;
    logic       raw_strobe;
    logic       clear_i;
    logic [2:0] level_o;
    logic       overflow_o;
    logic [7:0] drop_cnt_o;

    int checks;
    int errors;

    key_ingress_fifo_if #(.KEY_W(8), .IDX_W(4)) stream_if ();

    key_ingress_fifo #(
        .KEY_W(8), .IDX_W(4), .DEPTH(4), .SYNC_STAGES(2)
    ) dut (
        .user_clock2 (user_clock2),
        .rst_n       (rst_n),
        .raw_key     (raw_key),
        .raw_strobe  (raw_strobe),
        .clear_i     (clear_i),
        .stream      (stream_if),
        .level_o     (level_o),
        .overflow_o  (overflow_o),
        .drop_cnt_o  (drop_cnt_o)
    );

    initial user_clock2 = 1'b0;
    always #5 user_clock2 = ~user_clock2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge user_clock2);
        @(negedge user_clock2);
    endtask

    // Key set up one cycle ahead, strobe high for three edges (push on the third), then low.
    task automatic send_key(input logic [7:0] k);
        raw_key = k;
        tick();
        raw_strobe = 1'b1;
        repeat (3) tick();
        raw_strobe = 1'b0;
        repeat (3) tick();
    endtask

    task automatic short_strobe();
        raw_strobe = 1'b1;
        tick();
        tick();
        raw_strobe = 1'b0;
        tick();
        tick();
    endtask

    task automatic expect_head(input logic [7:0] k, input logic [3:0] i);
        chk("head_valid", 32'(stream_if.key_valid_o), 32'd1);
        chk("head_key", 32'(stream_if.key_o), 32'(k));
        chk("head_idx", 32'(stream_if.idx_o), 32'(i));
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        raw_key = 8'h00;
        raw_strobe = 1'b0;
        clear_i = 1'b0;
        stream_if.key_ready_i = 1'b0;
        repeat (3) @(negedge user_clock2);

        chk("rst_level", 32'(level_o), 32'd0);
        chk("rst_valid", 32'(stream_if.key_valid_o), 32'd0);
        chk("rst_ovf", 32'(overflow_o), 32'd0);
        chk("rst_drop", 32'(drop_cnt_o), 32'd0);
        chk("rst_key", 32'(stream_if.key_o), 32'd0);
        chk("rst_idx", 32'(stream_if.idx_o), 32'd0);
        rst_n = 1'b1;
        repeat (4) tick();

        // Single key latency
        raw_key = 8'hA5;
        tick();
        raw_strobe = 1'b1;
        tick();
        tick();
        chk("lat_edge2_valid", 32'(stream_if.key_valid_o), 32'd0);
        tick();
        chk("lat_edge3_valid", 32'(stream_if.key_valid_o), 32'd1);
        chk("single_key", 32'(stream_if.key_o), 32'hA5);
        chk("single_idx", 32'(stream_if.idx_o), 32'hF);
        chk("single_level", 32'(level_o), 32'd1);
        tick();
        raw_strobe = 1'b0;
        repeat (3) tick();
        chk("held_one_push", 32'(level_o), 32'd1);
        stream_if.key_ready_i = 1'b1;
        tick();
        stream_if.key_ready_i = 1'b0;
        chk("single_pop_valid", 32'(stream_if.key_valid_o), 32'd0);
        chk("single_pop_level", 32'(level_o), 32'd0);

        // Backpressure fill with one overflow
        send_key(8'h01);
        send_key(8'h02);
        send_key(8'h03);
        send_key(8'h04);
        send_key(8'h05);
        chk("fill_level", 32'(level_o), 32'd4);
        chk("fill_ovf", 32'(overflow_o), 32'd1);
        chk("fill_drop", 32'(drop_cnt_o), 32'd1);
        stream_if.key_ready_i = 1'b1;
        expect_head(8'h01, 4'h1);
        expect_head(8'h02, 4'h2);
        expect_head(8'h03, 4'h3);
        expect_head(8'h04, 4'h4);
        chk("drain_valid", 32'(stream_if.key_valid_o), 32'd0);
        stream_if.key_ready_i = 1'b0;

        // Clear stats, then push into a full FIFO while the head leaves
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        chk("clr_ovf", 32'(overflow_o), 32'd0);
        chk("clr_drop", 32'(drop_cnt_o), 32'd0);
        send_key(8'h10);
        send_key(8'h11);
        send_key(8'h12);
        send_key(8'h13);
        chk("full_level", 32'(level_o), 32'd4);
        raw_key = 8'h33;
        tick();
        raw_strobe = 1'b1;
        tick();
        tick();
        stream_if.key_ready_i = 1'b1;
        tick();
        stream_if.key_ready_i = 1'b0;
        chk("pp_level", 32'(level_o), 32'd4);
        chk("pp_drop", 32'(drop_cnt_o), 32'd0);
        chk("pp_ovf", 32'(overflow_o), 32'd0);
        chk("pp_head", 32'(stream_if.key_o), 32'h11);
        raw_strobe = 1'b0;
        repeat (3) tick();
        chk("pp_level_hold", 32'(level_o), 32'd4);
        stream_if.key_ready_i = 1'b1;
        expect_head(8'h11, 4'h0);
        expect_head(8'h12, 4'h3);
        expect_head(8'h13, 4'h2);
        expect_head(8'h33, 4'h0);
        chk("pp_drain_valid", 32'(stream_if.key_valid_o), 32'd0);
        stream_if.key_ready_i = 1'b0;

        // Drop counter saturation
        send_key(8'h20);
        send_key(8'h21);
        send_key(8'h22);
        send_key(8'h23);
        for (int n = 0; n < 255; n++) short_strobe();
        tick();
        chk("sat_drop_255", 32'(drop_cnt_o), 32'd255);
        chk("sat_ovf", 32'(overflow_o), 32'd1);
        chk("sat_level", 32'(level_o), 32'd4);
        chk("sat_head", 32'(stream_if.key_o), 32'h20);
        for (int n = 0; n < 45; n++) short_strobe();
        tick();
        chk("sat_drop_hold", 32'(drop_cnt_o), 32'd255);

        // Clear coincident with a push
        stream_if.key_ready_i = 1'b1;
        repeat (4) tick();
        stream_if.key_ready_i = 1'b0;
        chk("pre_clr_valid", 32'(stream_if.key_valid_o), 32'd0);
        chk("pre_clr_drop", 32'(drop_cnt_o), 32'd255);
        send_key(8'h40);
        send_key(8'h41);
        send_key(8'h42);
        chk("pre_clr_level", 32'(level_o), 32'd3);
        raw_key = 8'h77;
        tick();
        raw_strobe = 1'b1;
        tick();
        tick();
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        chk("clr_level", 32'(level_o), 32'd0);
        chk("clr_valid", 32'(stream_if.key_valid_o), 32'd0);
        chk("clr_ovf2", 32'(overflow_o), 32'd0);
        chk("clr_drop2", 32'(drop_cnt_o), 32'd0);
        chk("clr_key", 32'(stream_if.key_o), 32'd0);
        tick();
        tick();
        raw_strobe = 1'b0;
        repeat (3) tick();
        chk("clr_no_repush", 32'(level_o), 32'd0);

        // Asynchronous reset mid-burst with a strobe held through release
        send_key(8'h50);
        send_key(8'h51);
        chk("mid_level", 32'(level_o), 32'd2);
        raw_key = 8'h55;
        tick();
        raw_strobe = 1'b1;
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("async_level", 32'(level_o), 32'd0);
        chk("async_valid", 32'(stream_if.key_valid_o), 32'd0);
        chk("async_key", 32'(stream_if.key_o), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        repeat (6) tick();
        chk("held_level", 32'(level_o), 32'd0);
        chk("held_valid", 32'(stream_if.key_valid_o), 32'd0);
        raw_strobe = 1'b0;
        repeat (3) tick();
        raw_strobe = 1'b1;
        repeat (3) tick();
        chk("retoggle_level", 32'(level_o), 32'd1);
        chk("retoggle_key", 32'(stream_if.key_o), 32'h55);
        chk("retoggle_idx", 32'(stream_if.idx_o), 32'h0);
        raw_strobe = 1'b0;
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
